// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default index/data widths, reserved register indices, arbiter FSM
// state type, and the index legality helper.
package regfile_wr_arbiter_pkg;

  localparam int unsigned REG_AW   = 4;
  localparam int unsigned REG_DW   = 16;

  // Reserved register indices. T is passed through untouched; the RF itself
  // performs its ==0 conversion.
  localparam int unsigned REG0_IDX = 0;
  localparam int unsigned T_IDX    = 14;
  localparam int unsigned PC_IDX   = 15;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } arb_state_e;

  // Writes to REG0 or PC are never performed through this port.
  function automatic logic idx_legal(input logic [31:0] idx);
    return (idx != REG0_IDX) && (idx != PC_IDX);
  endfunction

endpackage

// File: rtl/regfile_wr_fifo.sv
// Circular buffer of pending secondary register writes with index lookup.
// Latency: push visible at head/count one cycle after the accepting posedge.
// Backpressure: ready_o is registered and equals !full; push ignored when full.
// Ports: Clk/Rst; push_i/push_reg_i/push_dat_i enqueue; pop_i dequeues head;
//        head_reg_o/head_dat_o show the oldest entry; count_o/full_o/empty_o
//        report occupancy; rs/rt_query_i match against all valid entries.
module regfile_wr_fifo
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = REG_AW,
  parameter int unsigned DW    = REG_DW
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     push_i,
  input  logic [AW-1:0]            push_reg_i,
  input  logic [DW-1:0]            push_dat_i,
  input  logic                     pop_i,
  output logic [AW-1:0]            head_reg_o,
  output logic [DW-1:0]            head_dat_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     ready_o,
  input  logic [AW-1:0]            rs_query_i,
  input  logic [AW-1:0]            rt_query_i,
  output logic                     rs_match_o,
  output logic                     rt_match_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0]    reg_q [DEPTH];
  logic [DW-1:0]    dat_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             ready_q;
  logic             do_push, do_pop;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign do_push    = push_i & ~full_o;
  assign do_pop     = pop_i & ~empty_o;
  assign head_reg_o = reg_q[rd_ptr_q];
  assign head_dat_o = dat_q[rd_ptr_q];
  assign count_o    = count_q;
  assign ready_o    = ready_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers are PW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
      ready_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        reg_q[i] <= '0;
        dat_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      // Ready tracks next-cycle fullness so the registered flag is never stale.
      ready_q <= (count_d != CW'(DEPTH));
      if (do_push) begin
        reg_q[wr_ptr_q] <= push_reg_i;
        dat_q[wr_ptr_q] <= push_dat_i;
        vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= rd_ptr_q + PW'(1);
      end
    end
  end

  always_comb begin
    rs_match_o = 1'b0;
    rt_match_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (reg_q[i] == rs_query_i)) rs_match_o = 1'b1;
      if (vld_q[i] && (reg_q[i] == rt_query_i)) rt_match_o = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the RF write port between WB (fixed priority) and a buffered secondary requester.
// Latency: write port combinational in-cycle; secondary accept->RF write >= 1 cycle.
// Backpressure: SecReady=!full (registered); StallPipe after MAX_WAIT blocked head cycles.
// Ports: WbValid/WbReg/WbData from writeback; SecValid/SecReg/SecData/SecReady
//        from the secondary unit; RsQuery/RtQuery -> RsPending/RtPending for
//        decode interlock; RegWre/WriteReg/WriteData to the RF; StallPipe,
//        FifoCount, ProtoErr (sticky WbValid-while-stalled) status.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned AW       = REG_AW,
  parameter int unsigned DW       = REG_DW
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   WbValid,
  input  logic [AW-1:0]          WbReg,
  input  logic [DW-1:0]          WbData,
  input  logic                   SecValid,
  input  logic [AW-1:0]          SecReg,
  input  logic [DW-1:0]          SecData,
  output logic                   SecReady,
  input  logic [AW-1:0]          RsQuery,
  input  logic [AW-1:0]          RtQuery,
  output logic                   RsPending,
  output logic                   RtPending,
  output logic                   StallPipe,
  output logic                   RegWre,
  output logic [AW-1:0]          WriteReg,
  output logic [DW-1:0]          WriteData,
  output logic [$clog2(DEPTH):0] FifoCount,
  output logic                   ProtoErr
);

  localparam int unsigned AGW = $clog2(MAX_WAIT) + 1;

  logic          wb_win, blocked, pop, push;
  logic          fifo_full, fifo_empty, rs_match, rt_match;
  logic [AW-1:0] head_reg;
  logic [DW-1:0] head_dat;
  logic [AGW-1:0] age_q, age_d;
  arb_state_e    state_q, state_d;
  logic          proto_err_q, proto_err_d;

  // An illegal WB index does not claim the port, leaving the slot free.
  assign wb_win  = WbValid & idx_legal(32'(WbReg));
  assign blocked = ~fifo_empty & wb_win;
  assign pop     = ~fifo_empty & ~wb_win;
  // Illegal secondary indices still complete the handshake but are dropped.
  assign push    = SecValid & SecReady & idx_legal(32'(SecReg)) & ~fifo_full;

  regfile_wr_fifo #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (DW)
  ) u_fifo (
    .Clk       (Clk),
    .Rst       (Rst),
    .push_i    (push),
    .push_reg_i(SecReg),
    .push_dat_i(SecData),
    .pop_i     (pop),
    .head_reg_o(head_reg),
    .head_dat_o(head_dat),
    .count_o   (FifoCount),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .ready_o   (SecReady),
    .rs_query_i(RsQuery),
    .rt_query_i(RtQuery),
    .rs_match_o(rs_match),
    .rt_match_o(rt_match)
  );

  assign RsPending = rs_match & idx_legal(32'(RsQuery));
  assign RtPending = rt_match & idx_legal(32'(RtQuery));

  always_comb begin
    RegWre    = 1'b0;
    WriteReg  = '0;
    WriteData = '0;
    if (wb_win) begin
      RegWre    = 1'b1;
      WriteReg  = WbReg;
      WriteData = WbData;
    end else if (!fifo_empty) begin
      RegWre    = 1'b1;
      WriteReg  = head_reg;
      WriteData = head_dat;
    end
  end

  // Age saturates at MAX_WAIT-1; a non-empty FIFO with no pop means WB blocked the head.
  always_comb begin
    age_d = age_q;
    if (fifo_empty || pop) begin
      age_d = '0;
    end else if (age_q != AGW'(MAX_WAIT - 1)) begin
      age_d = age_q + AGW'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    proto_err_d = proto_err_q | (WbValid & StallPipe);
    case (state_q)
      ST_RUN: begin
        if (blocked && (age_q == AGW'(MAX_WAIT - 1))) state_d = ST_STALL;
      end
      ST_STALL: begin
        if (pop || fifo_empty) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= ST_RUN;
      age_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      age_q       <= age_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign StallPipe = (state_q == ST_STALL);
  assign ProtoErr  = proto_err_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed self-checking bench for regfile_wr_arbiter (DEPTH=4, MAX_WAIT=8, AW=4, DW=16).
// Inputs change 1ns after posedge; outputs are checked a few ns later, before negedge.
module tb_regfile_wr_arbiter;

  logic        Clk, Rst;
  logic        WbValid, SecValid;
  logic [3:0]  WbReg, SecReg, RsQuery, RtQuery;
  logic [15:0] WbData, SecData;
  logic        SecReady, RsPending, RtPending, StallPipe, RegWre, ProtoErr;
  logic [3:0]  WriteReg;
  logic [15:0] WriteData;
  logic [2:0]  FifoCount;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wr_arbiter #(.DEPTH(4), .MAX_WAIT(8), .AW(4), .DW(16)) dut (
    .Clk(Clk), .Rst(Rst),
    .WbValid(WbValid), .WbReg(WbReg), .WbData(WbData),
    .SecValid(SecValid), .SecReg(SecReg), .SecData(SecData), .SecReady(SecReady),
    .RsQuery(RsQuery), .RtQuery(RtQuery), .RsPending(RsPending), .RtPending(RtPending),
    .StallPipe(StallPipe), .RegWre(RegWre), .WriteReg(WriteReg), .WriteData(WriteData),
    .FifoCount(FifoCount), .ProtoErr(ProtoErr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic port(input string tag, input logic wre, input logic [3:0] r, input logic [15:0] d);
    chk({tag, "_wre"}, 32'(RegWre), 32'(wre));
    chk({tag, "_reg"}, 32'(WriteReg), 32'(r));
    chk({tag, "_dat"}, 32'(WriteData), 32'(d));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b0; WbValid = 0; WbReg = 0; WbData = 0;
    SecValid = 0; SecReg = 0; SecData = 0; RsQuery = 0; RtQuery = 0;

    // Reset state
    tick(); tick();
    chk("rst_ready", 32'(SecReady), 0);
    chk("rst_count", 32'(FifoCount), 0);
    chk("rst_stall", 32'(StallPipe), 0);
    chk("rst_perr", 32'(ProtoErr), 0);
    port("rst", 0, 0, 0);
    Rst = 1'b1;
    tick();
    chk("rel_ready", 32'(SecReady), 1);

    // 1: reset mid-drain with three entries queued behind WB
    WbValid = 1; WbReg = 1; WbData = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      SecValid = 1; SecReg = 4'(2 + i); SecData = 16'(i); tick();
    end
    SecValid = 0; #1;
    chk("t1_count3", 32'(FifoCount), 3);
    WbValid = 0; Rst = 1'b0; #1;
    chk("t1_rst_count", 32'(FifoCount), 0);
    chk("t1_rst_ready", 32'(SecReady), 0);
    port("t1_rst", 0, 0, 0);
    tick(); Rst = 1'b1; tick();
    chk("t1_ready", 32'(SecReady), 1);
    chk("t1_count", 32'(FifoCount), 0);
    chk("t1_wre", 32'(RegWre), 0);

    // 2: WB priority, then FIFO drain in the idle slot
    WbValid = 1; WbReg = 5; WbData = 16'h1234;
    SecValid = 1; SecReg = 6; SecData = 16'hAAAA;
    tick(); SecValid = 0; #1;
    port("t2_wb", 1, 5, 16'h1234);
    chk("t2_count", 32'(FifoCount), 1);
    WbValid = 0; #1;
    port("t2_fifo", 1, 6, 16'hAAAA);
    tick();
    chk("t2_count0", 32'(FifoCount), 0);
    chk("t2_idle", 32'(RegWre), 0);

    // 3: pending scoreboard
    RsQuery = 7; RtQuery = 0;
    WbValid = 1; WbReg = 2; WbData = 16'h0002;
    SecValid = 1; SecReg = 7; SecData = 16'h7777;
    tick(); SecValid = 0; #1;
    chk("t3_rs_pend", 32'(RsPending), 1);
    chk("t3_rt_reg0", 32'(RtPending), 0);
    RsQuery = 0; RtQuery = 7; #1;
    chk("t3_rs_reg0", 32'(RsPending), 0);
    chk("t3_rt_pend", 32'(RtPending), 1);
    RsQuery = 7; tick();
    chk("t3_rs_hold", 32'(RsPending), 1);
    WbValid = 0; #1;
    chk("t3_pop_cycle", 32'(RsPending), 1);
    port("t3_pop", 1, 7, 16'h7777);
    tick();
    chk("t3_rs_clear", 32'(RsPending), 0);
    chk("t3_rt_clear", 32'(RtPending), 0);

    // 4a: ageing stall, WB releases the slot
    WbValid = 1; WbReg = 3; WbData = 16'h5555;
    SecValid = 1; SecReg = 8; SecData = 16'h8888;
    tick(); SecValid = 0;
    for (int c = 1; c <= 8; c++) begin
      chk("t4_no_stall", 32'(StallPipe), 0);
      tick();
    end
    chk("t4_stall9", 32'(StallPipe), 1);
    chk("t4_perr0", 32'(ProtoErr), 0);
    WbValid = 0; #1;
    port("t4_drain", 1, 8, 16'h8888);
    tick();
    chk("t4_unstall", 32'(StallPipe), 0);
    chk("t4_count0", 32'(FifoCount), 0);
    chk("t4_perr_ok", 32'(ProtoErr), 0);

    // 4b: WB ignores the stall -> sticky protocol error
    WbValid = 1; WbReg = 3; WbData = 16'h5555;
    SecValid = 1; SecReg = 9; SecData = 16'h9999;
    tick(); SecValid = 0;
    for (int c = 1; c <= 8; c++) tick();
    chk("t4b_stall", 32'(StallPipe), 1);
    port("t4b_wb_wins", 1, 3, 16'h5555);
    tick();
    chk("t4b_perr", 32'(ProtoErr), 1);
    chk("t4b_still_stall", 32'(StallPipe), 1);
    WbValid = 0; #1;
    port("t4b_drain", 1, 9, 16'h9999);
    tick();
    chk("t4b_unstall", 32'(StallPipe), 0);
    chk("t4b_perr_sticky", 32'(ProtoErr), 1);

    // Reset clears the sticky error
    Rst = 1'b0; #1;
    chk("rst2_perr", 32'(ProtoErr), 0);
    tick(); Rst = 1'b1; tick();

    // 5: fill to DEPTH, fifth request held, order preserved
    WbValid = 1; WbReg = 1; WbData = 16'h0001;
    SecValid = 1;
    for (int i = 0; i < 4; i++) begin
      SecReg = 4'(2 + i); SecData = 16'h1000 + 16'(i); tick();
    end
    chk("t5_full_cnt", 32'(FifoCount), 4);
    chk("t5_not_ready", 32'(SecReady), 0);
    SecReg = 6; SecData = 16'h1004; tick();
    chk("t5_held_cnt", 32'(FifoCount), 4);
    WbValid = 0; #1;
    port("t5_h0", 1, 2, 16'h1000);
    tick();
    chk("t5_cnt3", 32'(FifoCount), 3);
    chk("t5_ready", 32'(SecReady), 1);
    port("t5_h1", 1, 3, 16'h1001);
    tick(); SecValid = 0; #1;
    chk("t5_cnt_pushpop", 32'(FifoCount), 3);
    port("t5_h2", 1, 4, 16'h1002);
    tick();
    port("t5_h3", 1, 5, 16'h1003);
    tick();
    port("t5_h4", 1, 6, 16'h1004);
    tick();
    chk("t5_empty", 32'(FifoCount), 0);

    // 6: reserved indices
    WbValid = 1; WbReg = 0; WbData = 16'h1111;
    SecValid = 1; SecReg = 15; SecData = 16'hBEEF; #1;
    port("t6_wb_reg0", 0, 0, 0);
    tick(); SecValid = 0; #1;
    chk("t6_pc_dropped", 32'(FifoCount), 0);
    chk("t6_ready", 32'(SecReady), 1);
    WbReg = 15; SecValid = 1; SecReg = 5; SecData = 16'h0505;
    tick(); SecValid = 0; #1;
    port("t6_illegal_wb_frees", 1, 5, 16'h0505);
    WbReg = 14; WbData = 16'h0000; #1;
    port("t6_t_pass", 1, 14, 16'h0000);
    tick();
    chk("t6_t_cnt", 32'(FifoCount), 1);
    WbValid = 0; tick();
    chk("t6_final", 32'(FifoCount), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
